// File: rtl/iq_downmixer.sv
// I/Q downmixer: mixes a real sample stream with sin/cos, integrates and dumps over DECIM samples.
// Build option: define IQ_DOWNMIXER_ROUND_EN for round-half-up scaling instead of floor.
module iq_downmixer #(
    parameter int WIDTH  = 21,
    parameter int DWIDTH = 16,
    parameter int DECIM  = 8,
    parameter int OWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  sin,
    input  logic [WIDTH-1:0]  cos,
    input  logic [DWIDTH-1:0] din,
    input  logic              din_valid,
    input  logic              clear,
    output logic [OWIDTH-1:0] i_out,
    output logic [OWIDTH-1:0] q_out,
    output logic              out_valid,
    output logic              ovf
);
    localparam int PW = DWIDTH + WIDTH + 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = PW + CW;
    localparam logic signed [AW-1:0] OMAX = {{(AW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] OMIN = {{(AW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

    logic signed [DWIDTH-1:0] din_q;
    logic signed [WIDTH-1:0]  sin_q, cos_q;
    logic                     v1_q, v2_q;
    logic signed [PW-1:0]     pi_q, pq_q;
    logic signed [AW-1:0]     acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OWIDTH-1:0]        i_out_q, i_out_d, q_out_q, q_out_d;
    logic                     out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [OWIDTH:0]          sat_i, sat_q;

    // Returns {clipped, value}: scale the window sum by 2^-(WIDTH-1) and clamp to OWIDTH.
    function automatic logic [OWIDTH:0] scale_sat(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] r;
        logic signed [AW-1:0] sh;
`ifdef IQ_DOWNMIXER_ROUND_EN
        r = s + (AW'(1) <<< (WIDTH-2));
`else
        r = s;
`endif
        sh = r >>> (WIDTH-1);
        if (sh > OMAX)      scale_sat = {1'b1, OMAX[OWIDTH-1:0]};
        else if (sh < OMIN) scale_sat = {1'b1, OMIN[OWIDTH-1:0]};
        else                scale_sat = {1'b0, sh[OWIDTH-1:0]};
    endfunction

    // S1: capture; a sample arriving with clear becomes the first of the new window.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            din_q <= '0;
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            v1_q <= din_valid;
            if (din_valid) begin
                din_q <= $signed(din);
                sin_q <= $signed(sin);
                cos_q <= $signed(cos);
            end
        end
    end

    // S2: products
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q <= 1'b0;
            pi_q <= '0;
            pq_q <= '0;
        end else begin
            v2_q <= v1_q & ~clear;
            pi_q <= PW'(din_q) * PW'(cos_q);
            pq_q <= -(PW'(din_q) * PW'(sin_q));
        end
    end

    assign sat_i = scale_sat(acc_i_q + AW'(pi_q));
    assign sat_q = scale_sat(acc_q_q + AW'(pq_q));

    // S3: integrate and dump
    always_comb begin
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        cnt_d       = cnt_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        out_valid_d = 1'b0;
        ovf_d       = 1'b0;
        if (clear) begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
        end else if (v2_q) begin
            if (cnt_q == CW'(DECIM-1)) begin
                i_out_d     = sat_i[OWIDTH-1:0];
                q_out_d     = sat_q[OWIDTH-1:0];
                ovf_d       = sat_i[OWIDTH] | sat_q[OWIDTH];
                out_valid_d = 1'b1;
                acc_i_d     = '0;
                acc_q_d     = '0;
                cnt_d       = '0;
            end else begin
                acc_i_d = acc_i_q + AW'(pi_q);
                acc_q_d = acc_q_q + AW'(pq_q);
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            cnt_q       <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            cnt_q       <= cnt_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_iq_downmixer.sv
// Directed bench for iq_downmixer: reset, I/Q sign, saturation, gaps, back-to-back, clear and reset.
module tb_iq_downmixer;
    localparam int WIDTH  = 21;
    localparam int DWIDTH = 16;
    localparam int DECIM  = 8;
    localparam int OWIDTH = 16;
`ifdef IQ_DOWNMIXER_ROUND_EN
    localparam int EXP_I = 8000;
`else
    localparam int EXP_I = 7999;
`endif

    logic              clk = 1'b0;
    logic              reset, din_valid, clear;
    logic [WIDTH-1:0]  sin_s, cos_s;
    logic [DWIDTH-1:0] din;
    logic [OWIDTH-1:0] i_out, q_out;
    logic              out_valid, ovf;

    iq_downmixer #(.WIDTH(WIDTH), .DWIDTH(DWIDTH), .DECIM(DECIM), .OWIDTH(OWIDTH)) dut (
        .clk(clk), .reset(reset), .sin(sin_s), .cos(cos_s), .din(din),
        .din_valid(din_valid), .clear(clear), .i_out(i_out), .q_out(q_out),
        .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc, npulse, pcyc, ovf_bad;
    logic [OWIDTH-1:0] ci, cq;
    logic covf;

    // Drive one cycle's inputs, record any out_valid pulse seen mid-cycle, advance.
    task automatic step(input logic v, input int d, input int s, input int c,
                        input logic clr, input logic rst);
        din_valid = v; din = 16'(d); sin_s = 21'(s); cos_s = 21'(c);
        clear = clr; reset = rst;
        @(negedge clk);
        if (out_valid === 1'b1) begin
            npulse++; pcyc = cyc; ci = i_out; cq = q_out; covf = ovf;
        end else if (ovf !== 1'b0) ovf_bad++;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic start_run();
        cyc = 0; npulse = 0; pcyc = -1; ovf_bad = 0;
        ci = 'x; cq = 'x; covf = 1'bx;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        n_checks++; if (i_out !== 16'd0) begin n_fail++; $display("FAIL reset_i: got %0d want 0", i_out); end
        n_checks++; if (q_out !== 16'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_basic_i();
        start_run();
        for (int k = 0; k < 8; k++) step(1'b1, 1000, 0, 1048575, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (npulse != 1) begin n_fail++; $display("FAIL basic_npulse: got %0d want 1", npulse); end
        n_checks++; if (pcyc != 10) begin n_fail++; $display("FAIL basic_cycle: got %0d want 10", pcyc); end
        n_checks++; if (ci !== 16'(EXP_I)) begin n_fail++; $display("FAIL basic_i: got %0d want %0d", $signed(ci), EXP_I); end
        n_checks++; if (cq !== 16'd0) begin n_fail++; $display("FAIL basic_q: got %0d want 0", $signed(cq)); end
        n_checks++; if (covf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", covf); end
        n_checks++; if (ovf_bad != 0) begin n_fail++; $display("FAIL basic_ovf_idle: got %0d want 0", ovf_bad); end
    endtask

    task automatic test_q_sign();
        start_run();
        for (int k = 0; k < 8; k++) step(1'b1, 1000, 1048575, 0, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (npulse != 1 || pcyc != 10) begin n_fail++; $display("FAIL q_pulse: got %0d@%0d want 1@10", npulse, pcyc); end
        n_checks++; if (ci !== 16'd0) begin n_fail++; $display("FAIL q_i: got %0d want 0", $signed(ci)); end
        n_checks++; if (cq !== 16'(-8000)) begin n_fail++; $display("FAIL q_q: got %0d want -8000", $signed(cq)); end
    endtask

    task automatic test_saturation();
        start_run();
        for (int k = 0; k < 8; k++) step(1'b1, -32768, -1048576, -1048576, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (npulse != 1 || pcyc != 10) begin n_fail++; $display("FAIL sat_pulse: got %0d@%0d want 1@10", npulse, pcyc); end
        n_checks++; if (ci !== 16'h7fff) begin n_fail++; $display("FAIL sat_i: got %0d want 32767", $signed(ci)); end
        n_checks++; if (cq !== 16'h8000) begin n_fail++; $display("FAIL sat_q: got %0d want -32768", $signed(cq)); end
        n_checks++; if (covf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", covf); end
        start_run();
        for (int k = 0; k < 8; k++) step(1'b1, 0, -1048576, -1048576, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (covf !== 1'b0) begin n_fail++; $display("FAIL sat_next_ovf: got %b want 0", covf); end
        n_checks++; if (ci !== 16'd0 || cq !== 16'd0) begin n_fail++; $display("FAIL sat_next_iq: got %0d/%0d want 0/0", $signed(ci), $signed(cq)); end
        n_checks++; if (ovf_bad != 0) begin n_fail++; $display("FAIL sat_ovf_idle: got %0d want 0", ovf_bad); end
    endtask

    task automatic test_gapped();
        start_run();
        for (int k = 0; k < 16; k++) step(k % 2 == 0, 1000, 0, 1048575, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (npulse != 1) begin n_fail++; $display("FAIL gap_npulse: got %0d want 1", npulse); end
        n_checks++; if (pcyc != 17) begin n_fail++; $display("FAIL gap_cycle: got %0d want 17", pcyc); end
        n_checks++; if (ci !== 16'(EXP_I)) begin n_fail++; $display("FAIL gap_i: got %0d want %0d", $signed(ci), EXP_I); end
    endtask

    task automatic test_back_to_back();
        start_run();
        for (int k = 0; k < 16; k++) step(1'b1, 1000, 0, 1048575, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (npulse != 2) begin n_fail++; $display("FAIL b2b_npulse: got %0d want 2", npulse); end
        n_checks++; if (pcyc != 18) begin n_fail++; $display("FAIL b2b_cycle: got %0d want 18", pcyc); end
        n_checks++; if (ci !== 16'(EXP_I)) begin n_fail++; $display("FAIL b2b_i: got %0d want %0d", $signed(ci), EXP_I); end
    endtask

    task automatic test_clear();
        start_run();
        for (int k = 0; k < 5; k++) step(1'b1, 1000, 0, 1048575, 1'b0, 1'b0);
        step(1'b1, 1000, 0, 1048575, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b1, 1000, 0, 1048575, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (npulse != 1) begin n_fail++; $display("FAIL clear_npulse: got %0d want 1", npulse); end
        n_checks++; if (pcyc != 15) begin n_fail++; $display("FAIL clear_cycle: got %0d want 15", pcyc); end
        n_checks++; if (ci !== 16'(EXP_I)) begin n_fail++; $display("FAIL clear_i: got %0d want %0d", $signed(ci), EXP_I); end
    endtask

    task automatic test_reset_mid();
        start_run();
        for (int k = 0; k < 6; k++) step(1'b1, 1000, 0, 1048575, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b1);
        n_checks++; if (i_out !== 16'd0 || q_out !== 16'd0) begin n_fail++; $display("FAIL rstmid_iq: got %0d/%0d want 0/0", $signed(i_out), $signed(q_out)); end
        idle(4);
        n_checks++; if (npulse != 0) begin n_fail++; $display("FAIL rstmid_discard: got %0d pulses want 0", npulse); end
        start_run();
        for (int k = 0; k < 8; k++) step(1'b1, 1000, 0, 1048575, 1'b0, 1'b0);
        idle(4);
        n_checks++; if (npulse != 1 || pcyc != 10) begin n_fail++; $display("FAIL rstmid_pulse: got %0d@%0d want 1@10", npulse, pcyc); end
        n_checks++; if (ci !== 16'(EXP_I)) begin n_fail++; $display("FAIL rstmid_i: got %0d want %0d", $signed(ci), EXP_I); end
        n_checks++; if (cq !== 16'd0) begin n_fail++; $display("FAIL rstmid_q: got %0d want 0", $signed(cq)); end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; din_valid = 1'b0; din = '0; sin_s = '0; cos_s = '0;
        cyc = 0;
        @(posedge clk); #1;
        test_reset();
        test_basic_i();
        test_q_sign();
        test_saturation();
        test_gapped();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
